// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams a word-counted, XOR-checksummed image into instruction memory
// and holds the CPU in reset until the image is complete and verified.
module imem_boot_loader #(
  parameter int ADDR_W = 8,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_HDR_HI, S_HDR_LO, S_PAYLOAD, S_CSUM, S_DONE, S_ERROR
  } state_t;

  // Largest legal word count is the full memory capacity.
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       idx_q, idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [7:0]        csum_q, csum_d;
  logic              byte_ready_q, byte_ready_d;
  logic              im_we_q, im_we_d;
  logic [ADDR_W-1:0] im_addr_q, im_addr_d;
  logic [31:0]       im_wdata_q, im_wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              xfer;
  logic              word_wr;
  logic [31:0]       word;

  assign xfer = byte_valid && byte_ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HDR_HI;
      n_q          <= '0;
      idx_q        <= '0;
      asm_q        <= '0;
      bcnt_q       <= '0;
      csum_q       <= '0;
      byte_ready_q <= 1'b1;
      im_we_q      <= 1'b0;
      im_addr_q    <= ADDR_W'(BASE);
      im_wdata_q   <= '0;
      cpu_rst_q    <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      bcnt_q       <= bcnt_d;
      csum_q       <= csum_d;
      byte_ready_q <= byte_ready_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      cpu_rst_q    <= cpu_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    bcnt_d  = bcnt_q;
    csum_d  = csum_q;
    word_wr = 1'b0;
    word    = {asm_q, byte_data};
    case (state_q)
      S_HDR_HI: if (xfer) begin
        n_d     = {byte_data, n_q[7:0]};
        state_d = S_HDR_LO;
      end
      S_HDR_LO: if (xfer) begin
        n_d = {n_q[15:8], byte_data};
        if ({1'b0, n_d} > CAP)    state_d = S_ERROR;
        else if (n_d == 16'd0)    state_d = S_CSUM;
        else                      state_d = S_PAYLOAD;
      end
      S_PAYLOAD: if (xfer) begin
        csum_d = csum_q ^ byte_data;
        bcnt_d = bcnt_q + 2'd1;
        asm_d  = {asm_q[15:0], byte_data};
        if (bcnt_q == 2'd3) begin
          word_wr = 1'b1;
          idx_d   = idx_q + 16'd1;
          if (idx_q == n_q - 16'd1) state_d = S_CSUM;
        end
      end
      S_CSUM: if (xfer) begin
        state_d = (byte_data == csum_q) ? S_DONE : S_ERROR;
      end
      default: state_d = state_q;
    endcase
  end

  // Outputs are registered from the next state so they track it with no extra cycle.
  always_comb begin
    byte_ready_d = (state_d != S_DONE) && (state_d != S_ERROR);
    cpu_rst_d    = (state_d != S_DONE);
    done_d       = (state_d == S_DONE);
    err_d        = (state_d == S_ERROR);
    im_we_d      = word_wr;
    im_addr_d    = im_addr_q;
    im_wdata_d   = im_wdata_q;
    if (word_wr) begin
      im_addr_d  = ADDR_W'(BASE) + idx_q[ADDR_W-1:0];
      im_wdata_d = word;
    end
  end

  assign byte_ready = byte_ready_q;
  assign im_we      = im_we_q;
  assign im_addr    = im_addr_q;
  assign im_wdata   = im_wdata_q;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;
  localparam int ADDR_W = 8;
  localparam int BASE   = 0;

  logic              clk = 1'b0;
  logic              rst;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  logic [39:0] wr_q[$];
  logic [39:0] exp_w[$];
  logic [7:0]  img[$];
  logic        exp_done;
  logic        exp_err;
  int          exp_used;

  typedef struct {
    logic [15:0] hdr;
    int          nwords;
    logic [7:0]  flip;
    int          max_gap;
    logic        exp_done;
    logic        exp_err;
    int          exp_writes;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  imem_boot_loader #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always @(negedge clk) begin
    if (im_we === 1'b1) wr_q.push_back({im_addr, im_wdata});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    byte_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    wr_q.delete();
    chk("rst_ready", byte_ready, 1);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_we", im_we, 0);
    chk("rst_addr", im_addr, BASE);
    chk("rst_wdata", im_wdata, 0);
  endtask

  // Reference: decode the image from the format rules.
  task automatic model();
    int n;
    logic [7:0] cs;
    logic [31:0] w;
    exp_w.delete();
    exp_done = 1'b0;
    exp_err = 1'b0;
    n = int'({img[0], img[1]});
    if (n > (1 << ADDR_W)) begin
      exp_err = 1'b1;
      exp_used = 2;
      return;
    end
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = {img[2+4*i], img[3+4*i], img[4+4*i], img[5+4*i]};
      cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      exp_w.push_back({8'((BASE + i) % (1 << ADDR_W)), w});
    end
    exp_used = 2 + 4 * n + 1;
    if (img[exp_used-1] == cs) exp_done = 1'b1;
    else exp_err = 1'b1;
  endtask

  task automatic build(input logic [15:0] hdr, input int nw, input logic [7:0] flip);
    logic [31:0] w;
    logic [7:0] cs;
    cs = 8'h00;
    img.delete();
    img.push_back(hdr[15:8]);
    img.push_back(hdr[7:0]);
    for (int i = 0; i < nw; i++) begin
      w = (i == 0) ? 32'h20080005 : (i == 1) ? 32'h8C090004 : $urandom;
      for (int k = 3; k >= 0; k--) begin
        img.push_back(w[8*k +: 8]);
        cs = cs ^ w[8*k +: 8];
      end
    end
    img.push_back(cs ^ flip);
  endtask

  task automatic send_bytes(input int first, input int last, input int max_gap);
    int g;
    int ready_bad;
    ready_bad = 0;
    for (int i = first; i < last; i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 1)) : 0;
      for (int j = 0; j < g; j++) begin
        byte_valid = 1'b0;
        byte_data = 8'($urandom);
        step();
      end
      byte_valid = 1'b1;
      byte_data = img[i];
      if (byte_ready !== 1'b1) ready_bad++;
      step();
    end
    byte_valid = 1'b0;
    chk("ready_each_byte", ready_bad, 0);
  endtask

  task automatic check_end();
    int extra_bad;
    chk("end_done", done, exp_done);
    chk("end_err", err, exp_err);
    chk("end_cpu_rst", cpu_rst, !exp_done);
    chk("end_ready", byte_ready, 0);
    extra_bad = 0;
    for (int i = 0; i < 3; i++) begin
      byte_valid = 1'b1;
      byte_data = 8'($urandom);
      if (byte_ready !== 1'b0) extra_bad++;
      step();
    end
    byte_valid = 1'b0;
    step();
    chk("extra_not_accepted", extra_bad, 0);
    chk("terminal_hold", {done, err}, {exp_done, exp_err});
    chk("write_count", wr_q.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
      chk($sformatf("write_%0d", i), wr_q[i], exp_w[i]);
  endtask

  task automatic run(input int max_gap);
    model();
    do_reset();
    send_bytes(0, exp_used, max_gap);
    check_end();
  endtask

  initial begin
    rst = 1'b1;
    byte_valid = 1'b0;
    byte_data = 8'h00;

    tbl[0] = '{16'd2,      2,   8'h00, 0, 1'b1, 1'b0, 2};
    tbl[1] = '{16'd2,      2,   8'h01, 0, 1'b0, 1'b1, 2};
    tbl[2] = '{16'd0,      0,   8'h00, 0, 1'b1, 1'b0, 0};
    tbl[3] = '{16'h0101,   1,   8'h00, 0, 1'b0, 1'b1, 0};
    tbl[4] = '{16'd2,      2,   8'h00, 5, 1'b1, 1'b0, 2};
    tbl[5] = '{16'd5,      5,   8'h00, 2, 1'b1, 1'b0, 5};
    tbl[6] = '{16'h0100, 256,   8'h00, 0, 1'b1, 1'b0, 256};
    tbl[7] = '{16'hFFFF,   1,   8'h00, 0, 1'b0, 1'b1, 0};
    tbl[8] = '{16'd0,      0,   8'h5A, 0, 1'b0, 1'b1, 0};
    tbl[9] = '{16'd3,      3,   8'h80, 3, 1'b0, 1'b1, 3};

    do_reset();

    for (int t = 0; t < 10; t++) begin
      build(tbl[t].hdr, tbl[t].nwords, tbl[t].flip);
      run(tbl[t].max_gap);
      chk($sformatf("tbl%0d_done", t), done, tbl[t].exp_done);
      chk($sformatf("tbl%0d_err", t), err, tbl[t].exp_err);
      chk($sformatf("tbl%0d_writes", t), wr_q.size(), tbl[t].exp_writes);
    end

    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, 8'hAC};
    run(0);
    chk("lit_nwr", wr_q.size(), 2);
    if (wr_q.size() >= 2) begin
      chk("lit_w0", wr_q[0], 40'h00_20080005);
      chk("lit_w1", wr_q[1], 40'h01_8C090004);
    end
    chk("lit_done", done, 1);

    img = '{8'h00, 8'h00, 8'h00};
    run(0);
    chk("n0_nwr", wr_q.size(), 0);
    chk("n0_done", done, 1);

    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, 8'hAC};
    model();
    do_reset();
    send_bytes(0, 8, 0);
    byte_valid = 1'b1;
    byte_data = 8'h00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    byte_valid = 1'b0;
    chk("mid_nwr", wr_q.size(), 1);
    if (wr_q.size() >= 1) chk("mid_w0", wr_q[0], 40'h00_20080005);
    chk("mid_ready", byte_ready, 1);
    chk("mid_cpu_rst", cpu_rst, 1);
    chk("mid_addr", im_addr, BASE);
    chk("mid_wdata", im_wdata, 0);
    step();
    chk("mid_we", im_we, 0);
    send_bytes(0, exp_used, 1);
    step();
    chk("mid_total_wr", wr_q.size(), 3);
    if (wr_q.size() >= 3) begin
      chk("mid_r0", wr_q[1], 40'h00_20080005);
      chk("mid_r1", wr_q[2], 40'h01_8C090004);
    end
    chk("mid_done", done, 1);
    chk("mid_err", err, 0);
    chk("mid_cpu_rst_low", cpu_rst, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
